// File: rtl/arbitro_somador_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pkg_arbitro
// Description : Shared types and widths for the arbitro_somador slice.
// Revision    : 1.0 - initial release
// ============================================================================
package pkg_arbitro;

   localparam int LARG_OP  = 4;
   localparam int LARG_RES = 5;
   localparam int NUM_REQ  = 2;

   typedef enum logic [1:0] {
      OCIOSO   = 2'd0,
      CALCULO  = 2'd1,
      RESPOSTA = 2'd2
   } estado_t;

endpackage
`default_nettype wire

// File: rtl/arbitro_somador_mux.sv
`default_nettype none
// ============================================================================
// Module      : mux_somador
// Description : 4-bit A plus mux(B, C) into a 5-bit zero-extended sum.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_somador
   import pkg_arbitro::*;
(
   input  logic [LARG_OP-1:0]  entradaA,
   input  logic [LARG_OP-1:0]  entradaB,
   input  logic [LARG_OP-1:0]  entradaC,
   input  logic                sel_mux,
   output logic [LARG_RES-1:0] saida
);

   logic [LARG_OP-1:0] operando;

   // Select the second operand and add with one bit of headroom
   always_comb begin
      operando = sel_mux ? entradaC : entradaB;
      saida    = {1'b0, entradaA} + {1'b0, operando};
   end

endmodule
`default_nettype wire

// File: rtl/arbitro_somador.sv
`default_nettype none
// ============================================================================
// Module      : arbitro_somador
// Description : Round-robin arbiter and sequencer for two requesters sharing
//               a single mux_somador; returns tagged results over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module arbitro_somador
   import pkg_arbitro::*;
#(
   parameter int LARGURA_CONT = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [LARG_OP-1:0]      op_a0,
   input  logic [LARG_OP-1:0]      op_x0,
   input  logic [LARG_OP-1:0]      op_a1,
   input  logic [LARG_OP-1:0]      op_x1,
   output logic                    resp_valid,
   input  logic                    resp_ready,
   output logic                    resp_id,
   output logic [LARG_RES-1:0]     resp_resultado,
   output logic [LARGURA_CONT-1:0] contador_ops,
   output logic                    ocupado
);

   estado_t             estado;
   estado_t             prox_estado;
   logic                ultimo;
   logic                gnt_id;
   logic                tem_pedido;
   logic                aceita;
   logic [LARG_OP-1:0]  reg_a;
   logic [LARG_OP-1:0]  reg_x;
   logic                reg_id;
   logic [LARG_OP-1:0]  entradaA;
   logic [LARG_OP-1:0]  entradaB;
   logic [LARG_OP-1:0]  entradaC;
   logic                sel_mux;
   logic [LARG_RES-1:0] soma;

   // Pick a winner: a lone requester wins, contention goes to the one not served last
   always_comb begin
      tem_pedido = |req_valid;
      gnt_id     = 1'b0;
      case (req_valid)
         2'b01:   gnt_id = 1'b0;
         2'b10:   gnt_id = 1'b1;
         2'b11:   gnt_id = ~ultimo;
         default: gnt_id = 1'b0;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) estado <= OCIOSO;
      else       estado <= prox_estado;
   end

   // Next state and grant; ready is masked while reset is held so nothing looks accepted
   always_comb begin
      prox_estado = estado;
      req_ready   = '0;
      case (estado)
         OCIOSO: begin
            if (tem_pedido && !reset) begin
               req_ready[gnt_id] = 1'b1;
               prox_estado       = CALCULO;
            end
         end
         CALCULO:  prox_estado = RESPOSTA;
         RESPOSTA: if (resp_ready) prox_estado = OCIOSO;
         default:  prox_estado = OCIOSO;
      endcase
   end

   assign aceita = (estado == OCIOSO) && ((req_valid & req_ready) != '0);

   // Operand latch, round-robin history, result capture and completion counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         reg_a          <= '0;
         reg_x          <= '0;
         reg_id         <= 1'b0;
         ultimo         <= 1'b1;
         resp_resultado <= '0;
         contador_ops   <= '0;
      end else begin
         if (aceita) begin
            reg_a  <= gnt_id ? op_a1 : op_a0;
            reg_x  <= gnt_id ? op_x1 : op_x0;
            reg_id <= gnt_id;
            ultimo <= gnt_id;
         end
         if (estado == CALCULO)
            resp_resultado <= soma;
         if ((estado == RESPOSTA) && resp_ready)
            contador_ops <= contador_ops + LARGURA_CONT'(1);
      end
   end

   // Adder is driven only from the latched operands; the unused input is held at zero
   always_comb begin
      entradaA = reg_a;
      entradaB = reg_id ? '0 : reg_x;
      entradaC = reg_id ? reg_x : '0;
      sel_mux  = reg_id;
   end

   mux_somador u_mux_somador (
      .entradaA (entradaA),
      .entradaB (entradaB),
      .entradaC (entradaC),
      .sel_mux  (sel_mux),
      .saida    (soma)
   );

   assign resp_valid = (estado == RESPOSTA);
   assign resp_id    = reg_id;
   assign ocupado    = (estado != OCIOSO);

endmodule
`default_nettype wire
